// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one single-port word memory between the instruction
// fetch port (ic, reads only) and the load/store port (dc). One request per
// cycle is granted combinationally; an in-order tag FIFO remembers who issued
// each outstanding read so the in-order memory responses go back to the right
// requester.
module mem_req_arbiter #(
  parameter int WORD_ADDR_BITS = 30,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_OUTST      = 2,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req_val,
  output logic                      ic_req_rdy,
  input  logic [WORD_ADDR_BITS-1:0] ic_req_addr,
  output logic                      ic_resp_val,
  output logic [DATA_WIDTH-1:0]     ic_resp_data,
  input  logic                      dc_req_val,
  output logic                      dc_req_rdy,
  input  logic [WORD_ADDR_BITS-1:0] dc_req_addr,
  input  logic [DATA_WIDTH-1:0]     dc_req_data,
  input  logic [3:0]                dc_req_write,
  output logic                      dc_resp_val,
  output logic [DATA_WIDTH-1:0]     dc_resp_data,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_data,
  output logic [3:0]                mem_req_write,
  input  logic                      mem_resp_val,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data,
  output logic                      err_spurious
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  // Tag values stored in the FIFO: which port issued the read.
  localparam logic TAG_IC = 1'b0;
  localparam logic TAG_DC = 1'b1;

  typedef struct packed {
    logic [WORD_ADDR_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
    logic [3:0]                write;
  } req_t;

  req_t ic_req, dc_req, win_req;

  logic [MAX_OUTST-1:0] tag_q;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 last_dc;   // 1: dc was granted most recently

  logic fifo_empty, fifo_full, pop, push, rd_ok;
  logic dc_is_wr, ic_cand, dc_cand, grant_ic, grant_dc, accept;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTST - 1)) return '0;
    else                            return p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(MAX_OUTST));
  assign pop        = mem_resp_val & ~fifo_empty;
  // A response popping this cycle frees a slot for a new read.
  assign rd_ok      = ~fifo_full | mem_resp_val;

  assign dc_is_wr = |dc_req_write;
  assign ic_cand  = ic_req_val & rd_ok;
  assign dc_cand  = dc_req_val & (dc_is_wr | rd_ok);

  assign ic_req = '{addr: ic_req_addr, data: dc_req_data, write: 4'b0000};
  assign dc_req = '{addr: dc_req_addr, data: dc_req_data, write: dc_req_write};

  // Arbitration and request mux; only the winner sees mem_req_rdy.
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (dc_cand && ic_cand) begin
      if (ROUND_ROBIN != 0) grant_dc = ~last_dc;
      else                  grant_dc = 1'b1;
      grant_ic = ~grant_dc;
    end else begin
      grant_dc = dc_cand;
      grant_ic = ic_cand;
    end
    win_req = grant_dc ? dc_req : ic_req;
  end

  assign mem_req_val   = grant_ic | grant_dc;
  assign mem_req_addr  = win_req.addr;
  assign mem_req_data  = win_req.data;
  assign mem_req_write = win_req.write;
  assign ic_req_rdy    = grant_ic & mem_req_rdy;
  assign dc_req_rdy    = grant_dc & mem_req_rdy;

  assign accept = mem_req_val & mem_req_rdy;
  assign push   = accept & (grant_ic | (grant_dc & ~dc_is_wr));

  // Responses go to whoever owns the head tag; nothing is routed when empty.
  assign ic_resp_val  = pop & (tag_q[rd_ptr] == TAG_IC);
  assign dc_resp_val  = pop & (tag_q[rd_ptr] == TAG_DC);
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;

  // Tag FIFO, last-grant pointer and sticky spurious-response flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last_dc      <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (accept) last_dc <= grant_dc;
      if (push) begin
        tag_q[wr_ptr] <= grant_dc ? TAG_DC : TAG_IC;
        wr_ptr        <= inc_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= inc_ptr(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (mem_resp_val && fifo_empty) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: u_rr is the round-robin build, u_fp the
// fixed-priority build; both see the same stimulus.
module tb_mem_req_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_val, dc_req_val, mem_req_rdy, mem_resp_val;
  logic [AW-1:0] ic_req_addr, dc_req_addr;
  logic [DW-1:0] dc_req_data, mem_resp_data;
  logic [3:0]    dc_req_write;

  logic          ic_req_rdy, dc_req_rdy, ic_resp_val, dc_resp_val, mem_req_val, err_spurious;
  logic [DW-1:0] ic_resp_data, dc_resp_data, mem_req_data;
  logic [AW-1:0] mem_req_addr;
  logic [3:0]    mem_req_write;

  logic          ic_req_rdy_f, dc_req_rdy_f, ic_resp_val_f, dc_resp_val_f, mem_req_val_f, err_spurious_f;
  logic [DW-1:0] ic_resp_data_f, dc_resp_data_f, mem_req_data_f;
  logic [AW-1:0] mem_req_addr_f;
  logic [3:0]    mem_req_write_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.WORD_ADDR_BITS(AW), .DATA_WIDTH(DW), .MAX_OUTST(2), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset),
    .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
    .ic_resp_val(ic_resp_val), .ic_resp_data(ic_resp_data),
    .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_write(dc_req_write),
    .dc_resp_val(dc_resp_val), .dc_resp_data(dc_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .err_spurious(err_spurious)
  );

  mem_req_arbiter #(.WORD_ADDR_BITS(AW), .DATA_WIDTH(DW), .MAX_OUTST(2), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(reset),
    .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy_f), .ic_req_addr(ic_req_addr),
    .ic_resp_val(ic_resp_val_f), .ic_resp_data(ic_resp_data_f),
    .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy_f), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_write(dc_req_write),
    .dc_resp_val(dc_resp_val_f), .dc_resp_data(dc_resp_data_f),
    .mem_req_val(mem_req_val_f), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr_f),
    .mem_req_data(mem_req_data_f), .mem_req_write(mem_req_write_f),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .err_spurious(err_spurious_f)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ic_req_val = 0; dc_req_val = 0; mem_req_rdy = 0; mem_resp_val = 0;
    ic_req_addr = '0; dc_req_addr = '0; dc_req_data = '0; mem_resp_data = '0;
    dc_req_write = 4'b0000;
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // 1: idle after reset
    chk("idle_mem_req_val", mem_req_val, 0);
    chk("idle_ic_resp_val", ic_resp_val, 0);
    chk("idle_dc_resp_val", dc_resp_val, 0);
    chk("idle_err", err_spurious, 0);
    chk("idle_err_fp", err_spurious_f, 0);

    // 2: simultaneous reads, dc wins first tie, then ic; in-order responses
    ic_req_val = 1; ic_req_addr = 30'h10;
    dc_req_val = 1; dc_req_addr = 30'h20; mem_req_rdy = 1;
    #1;
    chk("t2_c0_val", mem_req_val, 1);
    chk("t2_c0_addr", mem_req_addr, 30'h20);
    chk("t2_c0_dc_rdy", dc_req_rdy, 1);
    chk("t2_c0_ic_rdy", ic_req_rdy, 0);
    chk("t2_c0_write", mem_req_write, 0);
    cyc();
    dc_req_val = 0;
    #1;
    chk("t2_c1_addr", mem_req_addr, 30'h10);
    chk("t2_c1_ic_rdy", ic_req_rdy, 1);
    cyc();
    ic_req_val = 0;
    mem_resp_val = 1; mem_resp_data = 32'hAAAA;
    #1;
    chk("t2_r0_dc_val", dc_resp_val, 1);
    chk("t2_r0_ic_val", ic_resp_val, 0);
    chk("t2_r0_dc_data", dc_resp_data, 32'hAAAA);
    cyc();
    mem_resp_data = 32'hBBBB;
    #1;
    chk("t2_r1_ic_val", ic_resp_val, 1);
    chk("t2_r1_dc_val", dc_resp_val, 0);
    chk("t2_r1_ic_data", ic_resp_data, 32'hBBBB);
    cyc();
    mem_resp_val = 0;

    // 3: dc masked write beside an ic read; write pushes no tag
    dc_req_val = 1; dc_req_addr = 30'h5; dc_req_data = 32'hDEAD; dc_req_write = 4'b0011;
    ic_req_val = 1; ic_req_addr = 30'h30;
    #1;
    chk("t3_wr_dc_rdy", dc_req_rdy, 1);
    chk("t3_wr_addr", mem_req_addr, 30'h5);
    chk("t3_wr_mask", mem_req_write, 4'b0011);
    chk("t3_wr_data", mem_req_data, 32'hDEAD);
    cyc();
    dc_req_val = 0; dc_req_write = 4'b0000;
    #1;
    chk("t3_rd_ic_rdy", ic_req_rdy, 1);
    chk("t3_rd_addr", mem_req_addr, 30'h30);
    chk("t3_rd_mask", mem_req_write, 4'b0000);
    cyc();
    ic_req_val = 0;
    mem_resp_val = 1; mem_resp_data = 32'h1234;
    #1;
    chk("t3_resp_ic", ic_resp_val, 1);
    chk("t3_resp_dc", dc_resp_val, 0);
    cyc();
    mem_resp_val = 0;

    // 4: backpressure from memory, then FIFO full, then pop frees a slot
    mem_req_rdy = 0; ic_req_val = 1; ic_req_addr = 30'h40;
    #1;
    chk("t4_nordy_val", mem_req_val, 1);
    chk("t4_nordy_ic_rdy", ic_req_rdy, 0);
    mem_req_rdy = 1;
    #1;
    chk("t4_rd0_rdy", ic_req_rdy, 1);
    cyc();
    ic_req_addr = 30'h41;
    #1;
    chk("t4_rd1_rdy", ic_req_rdy, 1);
    cyc();
    ic_req_addr = 30'h42;
    #1;
    chk("t4_full_rdy", ic_req_rdy, 0);
    chk("t4_full_val", mem_req_val, 0);
    cyc();
    chk("t4_full_rdy2", ic_req_rdy, 0);
    mem_resp_val = 1; mem_resp_data = 32'h77;
    #1;
    chk("t4_pop_rdy", ic_req_rdy, 1);
    chk("t4_pop_resp", ic_resp_val, 1);
    chk("t4_pop_data", ic_resp_data, 32'h77);
    cyc();
    ic_req_val = 0;
    #1;
    chk("t4_drain0", ic_resp_val, 1);
    cyc();
    #1;
    chk("t4_drain1", ic_resp_val, 1);
    cyc();
    mem_resp_val = 0;
    #1;
    chk("t4_no_err", err_spurious, 0);

    // 5: fixed priority starves ic while dc holds valid; round-robin alternates
    ic_req_val = 1; ic_req_addr = 30'h50;
    dc_req_val = 1; dc_req_addr = 30'h60;
    #1;
    chk("t5_fp_c0_dc_rdy", dc_req_rdy_f, 1);
    chk("t5_fp_c0_ic_rdy", ic_req_rdy_f, 0);
    chk("t5_rr_c0_dc_rdy", dc_req_rdy, 1);
    cyc();
    mem_resp_val = 1; mem_resp_data = 32'h5;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("t5_fp_dc_rdy", dc_req_rdy_f, 1);
      chk("t5_fp_ic_rdy", ic_req_rdy_f, 0);
      chk("t5_fp_addr", mem_req_addr_f, 30'h60);
      chk("t5_fp_dc_resp", dc_resp_val_f, 1);
      if (i == 1) begin
        chk("t5_rr_c1_ic_rdy", ic_req_rdy, 1);
        chk("t5_rr_c1_addr", mem_req_addr, 30'h50);
      end
      cyc();
    end
    dc_req_val = 0;
    #1;
    chk("t5_fp_ic_rdy_after", ic_req_rdy_f, 1);
    chk("t5_fp_addr_after", mem_req_addr_f, 30'h50);
    cyc();
    ic_req_val = 0;
    #1;
    chk("t5_fp_last_ic_resp", ic_resp_val_f, 1);
    chk("t5_rr_last_ic_resp", ic_resp_val, 1);
    cyc();
    mem_resp_val = 0;

    // 6: reset with reads in flight, then a stale response is flagged
    ic_req_val = 1; ic_req_addr = 30'h70;
    cyc();
    ic_req_addr = 30'h71;
    cyc();
    ic_req_val = 0;
    reset = 0;
    cyc();
    reset = 1;
    cyc();
    mem_resp_val = 1; mem_resp_data = 32'h99;
    #1;
    chk("t6_ic_resp", ic_resp_val, 0);
    chk("t6_dc_resp", dc_resp_val, 0);
    chk("t6_err_before", err_spurious, 0);
    cyc();
    mem_resp_val = 0;
    chk("t6_err", err_spurious, 1);
    chk("t6_err_fp", err_spurious_f, 1);
    cyc();
    chk("t6_err_sticky", err_spurious, 1);
    reset = 0;
    cyc();
    chk("t6_err_cleared", err_spurious, 0);
    reset = 1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
